// File: rtl/mtr_drv_pkg.sv
// Shared constants and channel state encoding
// for the motor PWM drive stage.
package mtr_drv_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] CNT_MAX = 11'h7FF;
  localparam int DEAD_PERIODS_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } chan_st_e;

endpackage

// File: rtl/mtr_drv_chan.sv
// One H-bridge channel: duty/dir latches, the
// IDLE/DRIVE/DEAD FSM and the registered gate pair.
module mtr_chan
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bnd,
  input  logic [PWM_W-1:0] cnt,
  input  logic [PWM_W-1:0] spd,
  input  logic             rev,
  output logic             pwm_frwrd,
  output logic             pwm_rev
);

  localparam logic [1:0] DEAD_LD = 2'(DEAD_PERIODS - 1);

  chan_st_e         st, st_n;
  logic [PWM_W-1:0] duty_q, duty_n;
  logic             dir_q, dir_n;
  logic [1:0]       dcnt, dcnt_n;
  logic             drv;

  // State, latched command and dead counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      duty_q <= '0;
      dir_q  <= 1'b0;
      dcnt   <= '0;
    end else begin
      st     <= st_n;
      duty_q <= duty_n;
      dir_q  <= dir_n;
      dcnt   <= dcnt_n;
    end
  end

  // Next state; commands are only sampled
  // on the period boundary.
  always_comb begin
    st_n   = st;
    duty_n = duty_q;
    dir_n  = dir_q;
    dcnt_n = dcnt;
    if (!en) begin
      st_n   = IDLE;
      dcnt_n = '0;
    end else if (bnd) begin
      duty_n = spd;
      dir_n  = rev;
      unique case (st)
        IDLE: st_n = DRIVE;
        DRIVE: begin
          if (rev != dir_q) begin
            st_n   = DEAD;
            dcnt_n = DEAD_LD;
          end
        end
        DEAD: begin
          if (dcnt == 2'd0) st_n = DRIVE;
          else dcnt_n = dcnt - 2'd1;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // Both gates derive from one dir bit, so
  // they can never be high together.
  assign drv = en && (st == DRIVE) &&
               (cnt < duty_q);

  // Registered gate outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_frwrd <= 1'b0;
      pwm_rev   <= 1'b0;
    end else begin
      pwm_frwrd <= drv && !dir_q;
      pwm_rev   <= drv && dir_q;
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// Motor drive stage: shared period counter and
// two independent PWM channels.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] lft_spd,
  input  logic             lft_rev,
  input  logic [PWM_W-1:0] rght_spd,
  input  logic             rght_rev,
  output logic             PWM_frwrd_lft,
  output logic             PWM_rev_lft,
  output logic             PWM_frwrd_rght,
  output logic             PWM_rev_rght,
  output logic             period_start
);

  logic [PWM_W-1:0] cnt;
  logic             bnd;

  assign bnd = (cnt == CNT_MAX);

  // Free-running period counter and
  // strobe aligned to cnt==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + 1'b1;
      period_start <= bnd;
    end
  end

  mtr_chan #(
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_lft (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bnd       (bnd),
    .cnt       (cnt),
    .spd       (lft_spd),
    .rev       (lft_rev),
    .pwm_frwrd (PWM_frwrd_lft),
    .pwm_rev   (PWM_rev_lft)
  );

  mtr_chan #(
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_rght (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bnd       (bnd),
    .cnt       (cnt),
    .spd       (rght_spd),
    .rev       (rght_rev),
    .pwm_frwrd (PWM_frwrd_rght),
    .pwm_rev   (PWM_rev_rght)
  );

endmodule
